// File: rtl/pp_job_scheduler.sv
// Round-robin job scheduler in front of the packet processor: grants one requester,
// pulses start, waits for irq or timeout, returns the PP status on a response channel.
// Latency: grant->start 1 cycle, irq->rsp_valid 1 cycle. Backpressure: rsp_ready low holds REPORT, no new grants.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid_i/req_addr_i/req_ready_o : per-requester job request, one-hot accept pulse
//   cfg_ignore_ecc_i                   : ECC-ignore setting, sampled at grant
//   start_o/addr_hdr_o/ignore_ecc_err_o: PP launch interface
//   busy_i/irq_i/pkt_*                 : PP progress and status
//   rsp_valid_o/rsp_ready_i/rsp_id_o/rsp_status_o : response channel
//   jobs_done_o                        : saturating count of jobs completed by irq
module pp_job_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 1023,
   localparam int IDW    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic                      cfg_ignore_ecc_i,
   output logic                      start_o,
   output logic [ADDR_W-1:0]         addr_hdr_o,
   output logic                      ignore_ecc_err_o,
   input  logic                      busy_i,
   input  logic                      irq_i,
   input  logic                      pkt_ecc_corr_i,
   input  logic                      pkt_ecc_uncorr_i,
   input  logic                      pkt_crc_err_i,
   input  logic [3:0]                pkt_byte_cnt_i,
   input  logic [3:0]                pkt_type_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [IDW-1:0]            rsp_id_o,
   output logic [11:0]               rsp_status_o,
   output logic [15:0]               jobs_done_o
);

   localparam int CW = $clog2(TIMEOUT + 1);
   // Expiry fires on the cycle the counter would reach TIMEOUT, so the job
   // spends exactly TIMEOUT cycles in the wait states before REPORT.
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_IRQ, REPORT} state_t;

   state_t          state, state_nxt;
   logic [IDW-1:0]  last_grant;
   logic [IDW-1:0]  grant_id;
   logic [IDW-1:0]  idx;
   logic            grant_found;
   logic [CW-1:0]   tmo_cnt;
   logic            grant;
   logic            capture;
   logic            expire;

   // Round-robin search starting just after the previous winner.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      idx         = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDW'((int'(last_grant) + k) % NUM_REQ);
         if (!grant_found && req_valid_i[idx]) begin
            grant_found = 1'b1;
            grant_id    = idx;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      req_ready_o = '0;
      start_o     = 1'b0;
      rsp_valid_o = 1'b0;
      grant       = 1'b0;
      capture     = 1'b0;
      expire      = 1'b0;
      case (state)
         IDLE: begin
            // Gated by reset so no accept pulse leaks out while reset is held.
            if (grant_found && !busy_i && reset) begin
               grant                 = 1'b1;
               req_ready_o[grant_id] = 1'b1;
               state_nxt             = START;
            end
         end
         START: begin
            start_o   = 1'b1;
            state_nxt = WAIT_BUSY;
         end
         WAIT_BUSY, WAIT_IRQ: begin
            // irq has priority over a simultaneous timeout expiry.
            if (irq_i) begin
               capture   = 1'b1;
               state_nxt = REPORT;
            end else if (tmo_cnt == TMO_LAST) begin
               expire    = 1'b1;
               state_nxt = REPORT;
            end else if (state == WAIT_BUSY && busy_i) begin
               state_nxt = WAIT_IRQ;
            end
         end
         REPORT: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant       <= IDW'(NUM_REQ - 1);
         addr_hdr_o       <= '0;
         ignore_ecc_err_o <= 1'b0;
         rsp_id_o         <= '0;
         rsp_status_o     <= '0;
         jobs_done_o      <= '0;
         tmo_cnt          <= '0;
      end else begin
         if (grant) begin
            addr_hdr_o       <= req_addr_i[grant_id*ADDR_W +: ADDR_W];
            ignore_ecc_err_o <= cfg_ignore_ecc_i;
            rsp_id_o         <= grant_id;
            last_grant       <= grant_id;
         end
         if (state == START) begin
            tmo_cnt <= '0;
         end else if (state == WAIT_BUSY || state == WAIT_IRQ) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (capture) begin
            rsp_status_o <= {1'b0, pkt_crc_err_i, pkt_ecc_uncorr_i, pkt_ecc_corr_i,
                             pkt_type_i, pkt_byte_cnt_i};
            if (jobs_done_o != 16'hFFFF) jobs_done_o <= jobs_done_o + 16'd1;
         end else if (expire) begin
            rsp_status_o <= 12'h800;
         end
      end
   end

endmodule

// File: tb/tb_pp_job_scheduler.sv
module tb_pp_job_scheduler;
   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 15;
   localparam int IDW     = 2;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [NUM_REQ-1:0]        req_valid_i;
   logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
   logic [NUM_REQ-1:0]        req_ready_o;
   logic                      cfg_ignore_ecc_i;
   logic                      start_o;
   logic [ADDR_W-1:0]         addr_hdr_o;
   logic                      ignore_ecc_err_o;
   logic                      busy_i, irq_i;
   logic                      pkt_ecc_corr_i, pkt_ecc_uncorr_i, pkt_crc_err_i;
   logic [3:0]                pkt_byte_cnt_i, pkt_type_i;
   logic                      rsp_valid_o, rsp_ready_i;
   logic [IDW-1:0]            rsp_id_o;
   logic [11:0]               rsp_status_o;
   logic [15:0]               jobs_done_o;

   pp_job_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
      .cfg_ignore_ecc_i(cfg_ignore_ecc_i), .start_o(start_o), .addr_hdr_o(addr_hdr_o),
      .ignore_ecc_err_o(ignore_ecc_err_o), .busy_i(busy_i), .irq_i(irq_i),
      .pkt_ecc_corr_i(pkt_ecc_corr_i), .pkt_ecc_uncorr_i(pkt_ecc_uncorr_i),
      .pkt_crc_err_i(pkt_crc_err_i), .pkt_byte_cnt_i(pkt_byte_cnt_i), .pkt_type_i(pkt_type_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
      .rsp_status_o(rsp_status_o), .jobs_done_o(jobs_done_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [11:0]    status;
   } rsp_t;

   rsp_t              sb_q[$];
   logic [ADDR_W-1:0] addr_tab[NUM_REQ];
   int                checks = 0;
   int                errors = 0;
   int                jobs_model = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Waits (bounded) for the accept pulse, checks the winner, pushes the expected
   // response and checks the launch cycle that follows.
   task automatic wait_grant(input int exp_g, input logic [11:0] exp_status);
      bit found = 1'b0;
      #1;
      for (int n = 0; n < 40 && !found; n++) begin
         if (req_ready_o != '0) found = 1'b1;
         else cyc();
      end
      check("grant_seen", 32'(found), 32'd1);
      if (found) begin
         check("grant_onehot", 32'(req_ready_o), 32'(1 << exp_g));
         sb_q.push_back('{id: IDW'(exp_g), status: exp_status});
         cyc();
         check("ready_single_pulse", 32'(req_ready_o), 32'd0);
         check("start_pulse", 32'(start_o), 32'd1);
         check("addr_hdr", addr_hdr_o, addr_tab[exp_g]);
         check("rsp_id_at_start", 32'(rsp_id_o), 32'(exp_g));
      end
   endtask

   // Plays the PP: busy for cycles 1..nbusy after START, irq pulse at cycle irq_at
   // (negative = never). Then holds rsp_ready low for 'hold' cycles and completes.
   task automatic finish_job(input int nbusy, input int irq_at, input logic [3:0] ptype,
                             input logic [3:0] pbc, input logic crc, input logic unc,
                             input logic cor, input int hold, input int exp_lat);
      bit   seen = 1'b0;
      int   w = 0;
      rsp_t e;
      while (!seen && w < 40) begin
         cyc();
         w++;
         if (w == 1) check("start_one_cycle", 32'(start_o), 32'd0);
         if (rsp_valid_o) begin
            seen = 1'b1;
         end else begin
            busy_i           = (w <= nbusy);
            irq_i            = (w == irq_at);
            pkt_type_i       = irq_i ? ptype : 4'h0;
            pkt_byte_cnt_i   = irq_i ? pbc : 4'h0;
            pkt_crc_err_i    = irq_i & crc;
            pkt_ecc_uncorr_i = irq_i & unc;
            pkt_ecc_corr_i   = irq_i & cor;
         end
      end
      busy_i = 1'b0; irq_i = 1'b0; pkt_type_i = '0; pkt_byte_cnt_i = '0;
      pkt_crc_err_i = 1'b0; pkt_ecc_uncorr_i = 1'b0; pkt_ecc_corr_i = 1'b0;
      check("rsp_seen", 32'(seen), 32'd1);
      check("rsp_latency", 32'(w), 32'(exp_lat));
      check("sb_not_empty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("rsp_id", 32'(rsp_id_o), 32'(e.id));
         check("rsp_status", 32'(rsp_status_o), 32'(e.status));
         for (int i = 0; i < hold; i++) begin
            cyc();
            check("bp_valid_held", 32'(rsp_valid_o), 32'd1);
            check("bp_status_stable", 32'(rsp_status_o), 32'(e.status));
            check("bp_no_grant", 32'(req_ready_o), 32'd0);
         end
         if (!e.status[11]) jobs_model++;
      end
      rsp_ready_i = 1'b1;
      cyc();
      rsp_ready_i = 1'b0;
      check("rsp_valid_drop", 32'(rsp_valid_o), 32'd0);
      check("jobs_done", 32'(jobs_done_o), 32'(jobs_model));
   endtask

   initial begin
      addr_tab[0] = 32'hBABABABA;
      addr_tab[1] = 32'h11112222;
      addr_tab[2] = 32'hA5A55A5A;
      addr_tab[3] = 32'hDEADBEEF;
      for (int i = 0; i < NUM_REQ; i++) req_addr_i[i*ADDR_W +: ADDR_W] = addr_tab[i];
      reset = 1'b0; req_valid_i = 4'b1111; cfg_ignore_ecc_i = 1'b1;
      busy_i = 1'b0; irq_i = 1'b0; rsp_ready_i = 1'b0;
      pkt_ecc_corr_i = 1'b0; pkt_ecc_uncorr_i = 1'b0; pkt_crc_err_i = 1'b0;
      pkt_byte_cnt_i = '0; pkt_type_i = '0;

      // Reset state
      #3;
      check("rst_req_ready", 32'(req_ready_o), 32'd0);
      check("rst_start", 32'(start_o), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_addr", addr_hdr_o, 32'd0);
      check("rst_ign", 32'(ignore_ecc_err_o), 32'd0);
      check("rst_rsp_id", 32'(rsp_id_o), 32'd0);
      check("rst_status", 32'(rsp_status_o), 32'd0);
      check("rst_jobs", 32'(jobs_done_o), 32'd0);
      cyc(); cyc();
      req_valid_i = 4'b0001;
      reset = 1'b1;

      // Single job: busy 3 cycles then irq, type 2 byte_cnt 9
      wait_grant(0, 12'h029);
      check("ign_ecc_latched", 32'(ignore_ecc_err_o), 32'd1);
      cfg_ignore_ecc_i = 1'b0;
      req_valid_i = 4'b0000;
      finish_job(3, 4, 4'h2, 4'h9, 1'b0, 1'b0, 1'b0, 0, 5);
      check("ign_ecc_held", 32'(ignore_ecc_err_o), 32'd1);

      // Round robin from a fresh reset, all requesters active
      reset = 1'b0; #1; cyc(); reset = 1'b1; jobs_model = 0;
      req_valid_i = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         wait_grant(k % 4, 12'(k * 16 + 10));
         finish_job(2, 3, 4'(k), 4'hA, 1'b0, 1'b0, 1'b0, 0, 4);
      end
      check("ign_ecc_regrant", 32'(ignore_ecc_err_o), 32'd0);

      // Timeout: PP never raises irq
      req_valid_i = 4'b0001;
      wait_grant(0, 12'h800);
      req_valid_i = 4'b0000;
      finish_job(2, -1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 0, TIMEOUT + 1);

      // Error status on a fast job (irq without busy)
      req_valid_i = 4'b0001;
      wait_grant(0, 12'h600);
      req_valid_i = 4'b0000;
      finish_job(0, 1, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 0, 2);

      // irq in the same cycle as timeout expiry wins
      req_valid_i = 4'b0001;
      wait_grant(0, 12'h153);
      req_valid_i = 4'b0000;
      finish_job(20, TIMEOUT, 4'h5, 4'h3, 1'b0, 1'b0, 1'b1, 0, TIMEOUT + 1);

      // Response backpressure with another request pending
      req_valid_i = 4'b0011;
      wait_grant(1, 12'h0C7);
      finish_job(1, 2, 4'hC, 4'h7, 1'b0, 1'b0, 1'b0, 10, 3);

      // busy_i in IDLE blocks granting
      busy_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("busy_gate", 32'(req_ready_o), 32'd0);
         cyc();
      end
      busy_i = 1'b0;
      wait_grant(0, 12'h011);
      req_valid_i = 4'b0000;
      finish_job(1, 2, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 0, 3);

      // Async reset while waiting for irq
      req_valid_i = 4'b0100;
      wait_grant(2, 12'h000);
      cyc();
      busy_i = 1'b1;
      cyc();
      req_valid_i = 4'b1111;
      #1;
      reset = 1'b0;
      #1;
      check("arst_start", 32'(start_o), 32'd0);
      check("arst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("arst_req_ready", 32'(req_ready_o), 32'd0);
      check("arst_addr", addr_hdr_o, 32'd0);
      check("arst_rsp_id", 32'(rsp_id_o), 32'd0);
      check("arst_jobs", 32'(jobs_done_o), 32'd0);
      sb_q.delete();
      jobs_model = 0;
      busy_i = 1'b0;
      cyc();
      reset = 1'b1;
      wait_grant(0, 12'h0E4);
      req_valid_i = 4'b0000;
      finish_job(0, 2, 4'hE, 4'h4, 1'b0, 1'b0, 1'b0, 0, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
